// File: rtl/kernel_sysid_pkg.sv
// kernel_sysid_pkg: shared word addresses, default image constants and FSM state encoding for the system-ID checker.
package kernel_sysid_pkg;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd2;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1504073683;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        DONE
    } sysid_state_t;

endpackage

// File: rtl/kernel_sysid_timeout_cnt.sv
// kernel_sysid_timeout_cnt: saturating per-access cycle counter.
// Ports: clock/reset_n (async active-low); clear zeroes the count; enable
// advances it (holding at all-ones); expired is high once count >= LIMIT.
module kernel_sysid_timeout_cnt #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIM = LIMIT[CNT_W-1:0];

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != '1)
            cnt <= cnt + 1'b1;
    end

    assign expired = cnt >= LIM;

endmodule

// File: rtl/kernel_sysid_checker.sv
// kernel_sysid_checker: Avalon-MM read initiator that fetches the system ID and build timestamp and checks them.
// Ports: clock, reset_n (async active-low); start request; Avalon master
// address/read/waitrequest/readdata/readdatavalid; status busy, done pulse,
// pass, id_match, ts_match, timeout; captured id_value and ts_value.
module kernel_sysid_checker
    import kernel_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          CNT_W              = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    input  logic        readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_t state;
    logic in_access, is_id, req, accept, take, expired, expire;

    assign is_id     = state == ID_REQ || state == ID_WAIT;
    assign req       = state == ID_REQ || state == TS_REQ;
    assign in_access = is_id || state == TS_REQ || state == TS_WAIT;
    assign accept    = req && read && !waitrequest;
    // In a request state data only counts once the read is accepted (zero latency);
    // in a wait state any readdatavalid completes the outstanding read.
    assign take      = readdatavalid && in_access && (accept || !req);
    // Data arriving in the expiry cycle takes priority over the timeout.
    assign expire    = expired && in_access && !take;

    kernel_sysid_timeout_cnt #(
        .CNT_W(CNT_W),
        .LIMIT(TIMEOUT_CYCLES)
    ) u_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (!in_access || (is_id && take)),
        .enable (in_access),
        .expired(expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            address  <= SYSID_ADDR_ID;
            read     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state    <= ID_REQ;
                    read     <= 1'b1;
                    address  <= SYSID_ADDR_ID;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    id_match <= 1'b0;
                    ts_match <= 1'b0;
                    timeout  <= 1'b0;
                    id_value <= '0;
                    ts_value <= '0;
                end
                ID_REQ, ID_WAIT, TS_REQ, TS_WAIT: begin
                    if (take && is_id) begin
                        id_value <= readdata;
                        id_match <= readdata == EXPECTED_ID;
                        state    <= TS_REQ;
                        read     <= 1'b1;
                        address  <= SYSID_ADDR_TS;
                    end else if (take) begin
                        ts_value <= readdata;
                        ts_match <= readdata == EXPECTED_TIMESTAMP;
                        pass     <= id_match && readdata == EXPECTED_TIMESTAMP;
                        state    <= DONE;
                        read     <= 1'b0;
                        done     <= 1'b1;
                    end else if (expire) begin
                        timeout <= 1'b1;
                        state   <= DONE;
                        read    <= 1'b0;
                        done    <= 1'b1;
                    end else if (accept) begin
                        state <= is_id ? ID_WAIT : TS_WAIT;
                        read  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// tb_kernel_sysid_checker: directed self-checking bench with a configurable Avalon responder model.
module tb_kernel_sysid_checker;

    localparam logic [31:0] GOOD_ID = 32'd2;
    localparam logic [31:0] GOOD_TS = 32'd1504073683;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        address, read, waitrequest, readdatavalid;
    logic [31:0] readdata;
    logic        busy, done, pass, id_match, ts_match, timeout;
    logic [31:0] id_value, ts_value;

    int n_checks = 0;
    int n_fail = 0;

    // responder configuration
    int          cfg_wait = 0;
    int          cfg_lat = 0;
    logic [31:0] cfg_id = GOOD_ID;
    logic [31:0] cfg_ts = GOOD_TS;
    logic        drop_ts = 1'b0;
    logic        inject = 1'b0;
    logic [31:0] inj_data = '0;

    int   wait_left = 0;
    logic pend = 1'b0;
    int   pend_cnt = 0;
    logic pend_addr = 1'b0;
    logic acc, imm_valid, del_valid;

    always #5 clock = ~clock;

    kernel_sysid_checker #(.TIMEOUT_CYCLES(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .address      (address),
        .read         (read),
        .waitrequest  (waitrequest),
        .readdata     (readdata),
        .readdatavalid(readdatavalid),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .id_match     (id_match),
        .ts_match     (ts_match),
        .timeout      (timeout),
        .id_value     (id_value),
        .ts_value     (ts_value)
    );

    assign waitrequest   = read && wait_left != 0;
    assign acc           = read && !waitrequest;
    assign imm_valid     = acc && cfg_lat == 0 && !(drop_ts && address);
    assign del_valid     = pend && pend_cnt == 0 && !(drop_ts && pend_addr);
    assign readdatavalid = imm_valid || del_valid || inject;
    assign readdata      = inject ? inj_data : ((pend ? pend_addr : address) ? cfg_ts : cfg_id);

    always @(posedge clock) begin
        if (!read || !waitrequest)
            wait_left <= cfg_wait;
        else
            wait_left <= wait_left - 1;
        if (!reset_n)
            pend <= 1'b0;
        else if (acc && cfg_lat != 0) begin
            pend      <= 1'b1;
            pend_cnt  <= cfg_lat - 1;
            pend_addr <= address;
        end else if (pend) begin
            if (pend_cnt == 0)
                pend <= 1'b0;
            else
                pend_cnt <= pend_cnt - 1;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic setup(input int w, input int l, input logic [31:0] id, input logic drop);
        cfg_wait = w;
        cfg_lat  = l;
        cfg_id   = id;
        drop_ts  = drop;
        tick;
        tick;
    endtask

    // Pulses start and returns the cycle index (start = cycle 0) where done is seen, or -1.
    task automatic start_and_wait(output int dcyc);
        start = 1'b1;
        tick;
        start = 1'b0;
        dcyc = -1;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                dcyc = c;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({busy, done, pass, id_match, ts_match, timeout, read, address} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000000", {busy, done, pass, id_match, ts_match, timeout, read, address});
        end
        n_checks++;
        if (id_value !== 32'd0 || ts_value !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: got id=%0d ts=%0d expected 0/0", id_value, ts_value);
        end
        tick;
        tick;
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        setup(0, 0, GOOD_ID, 1'b0);
        start = 1'b1;
        tick;
        start = 1'b0;
        n_checks++;
        if ({busy, read, address, done} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_cycle1: got busy/read/addr/done=%b expected 1100", {busy, read, address, done});
        end
        tick;
        n_checks++;
        if ({busy, read, address, done} !== 4'b1110) begin
            n_fail++;
            $display("FAIL b2b_cycle2: got busy/read/addr/done=%b expected 1110", {busy, read, address, done});
        end
        tick;
        n_checks++;
        if ({busy, done, pass, id_match, ts_match, timeout} !== 6'b111110) begin
            n_fail++;
            $display("FAIL b2b_done_flags: got %b expected 111110", {busy, done, pass, id_match, ts_match, timeout});
        end
        n_checks++;
        if (id_value !== GOOD_ID || ts_value !== GOOD_TS) begin
            n_fail++;
            $display("FAIL b2b_values: got id=%0d ts=%0d expected 2/1504073683", id_value, ts_value);
        end
        tick;
        n_checks++;
        if ({busy, done, pass} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_persist: got busy/done/pass=%b expected 001", {busy, done, pass});
        end
    endtask

    task automatic test_id_mismatch;
        int d;
        setup(0, 0, 32'd3, 1'b0);
        start_and_wait(d);
        n_checks++;
        if (d != 3) begin
            n_fail++;
            $display("FAIL mismatch_done_cycle: got %0d expected 3", d);
        end
        n_checks++;
        if ({pass, id_match, ts_match, timeout} !== 4'b0010 || id_value !== 32'd3) begin
            n_fail++;
            $display("FAIL mismatch_flags: got p/im/tm/to=%b id=%0d expected 0010 id=3", {pass, id_match, ts_match, timeout}, id_value);
        end
    endtask

    task automatic test_waitrequest;
        int d = -1;
        int waits = 0;
        int stab_err = 0;
        logic prev_wait = 1'b0;
        logic prev_addr = 1'b0;
        setup(5, 2, GOOD_ID, 1'b0);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (prev_wait && (read !== 1'b1 || address !== prev_addr))
                stab_err++;
            if (waitrequest)
                waits++;
            prev_wait = waitrequest;
            prev_addr = address;
            if (done) begin
                d = c;
                break;
            end
            tick;
        end
        n_checks++;
        if (d != 17) begin
            n_fail++;
            $display("FAIL wait_done_cycle: got %0d expected 17", d);
        end
        n_checks++;
        if (stab_err != 0 || waits != 10) begin
            n_fail++;
            $display("FAIL wait_stability: got errors=%0d waits=%0d expected 0/10", stab_err, waits);
        end
        n_checks++;
        if ({pass, id_match, ts_match, timeout} !== 4'b1110) begin
            n_fail++;
            $display("FAIL wait_flags: got %b expected 1110", {pass, id_match, ts_match, timeout});
        end
    endtask

    task automatic test_timeout;
        int d;
        setup(0, 0, GOOD_ID, 1'b1);
        start_and_wait(d);
        n_checks++;
        if (d != 11) begin
            n_fail++;
            $display("FAIL ts_timeout_cycle: got %0d expected 11", d);
        end
        n_checks++;
        if ({pass, id_match, ts_match, timeout} !== 4'b0101) begin
            n_fail++;
            $display("FAIL ts_timeout_flags: got %b expected 0101", {pass, id_match, ts_match, timeout});
        end
        tick;
        tick;
        tick;
        inj_data = GOOD_TS;
        inject = 1'b1;
        tick;
        inject = 1'b0;
        tick;
        n_checks++;
        if (ts_value !== 32'd0 || {busy, ts_match, timeout} !== 3'b001) begin
            n_fail++;
            $display("FAIL late_valid: got ts=%0d busy/tm/to=%b expected 0 001", ts_value, {busy, ts_match, timeout});
        end
        setup(0, 9, GOOD_ID, 1'b0);
        start_and_wait(d);
        n_checks++;
        if (d != 10 || {pass, id_match, ts_match, timeout} !== 4'b0001 || id_value !== 32'd0) begin
            n_fail++;
            $display("FAIL id_timeout: got cycle=%0d flags=%b id=%0d expected 10 0001 0", d, {pass, id_match, ts_match, timeout}, id_value);
        end
    endtask

    task automatic test_data_wins;
        int d;
        setup(0, 8, GOOD_ID, 1'b0);
        start_and_wait(d);
        n_checks++;
        if (d != 19 || {pass, id_match, ts_match, timeout} !== 4'b1110) begin
            n_fail++;
            $display("FAIL data_wins: got cycle=%0d flags=%b expected 19 1110", d, {pass, id_match, ts_match, timeout});
        end
    endtask

    task automatic test_start_while_busy;
        int dones = 0;
        int d = -1;
        setup(0, 0, GOOD_ID, 1'b0);
        start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c == 4)
                start = 1'b0;
            if (done) begin
                dones++;
                d = c;
            end
            if (c == 5) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_restart: got busy=%b expected 0", busy);
                end
            end
        end
        n_checks++;
        if (dones != 1 || d != 3) begin
            n_fail++;
            $display("FAIL start_ignored: got dones=%0d at %0d expected 1 at 3", dones, d);
        end
    endtask

    task automatic test_reset_mid;
        int dones = 0;
        int d;
        setup(0, 3, 32'd3, 1'b0);
        start = 1'b1;
        tick;
        tick;
        tick;
        start = 1'b0;
        tick;
        tick;
        tick;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, pass, id_match, ts_match, timeout, read, address} !== 8'b0 || id_value !== 32'd0 || ts_value !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got flags=%b id=%0d ts=%0d expected all 0", {busy, done, pass, id_match, ts_match, timeout, read, address}, id_value, ts_value);
        end
        tick;
        tick;
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done || busy)
                dones++;
            tick;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d busy/done cycles expected 0", dones);
        end
        setup(0, 0, GOOD_ID, 1'b0);
        start_and_wait(d);
        n_checks++;
        if (d != 3 || pass !== 1'b1 || ts_value !== GOOD_TS) begin
            n_fail++;
            $display("FAIL after_reset_run: got cycle=%0d pass=%b ts=%0d expected 3 1 1504073683", d, pass, ts_value);
        end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_id_mismatch;
        test_waitrequest;
        test_timeout;
        test_data_wins;
        test_start_while_busy;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
